one2five_tx: RTL and testbench

Transmit-side counterpart of the five-copy redundancy receiver. It captures one payload frame from the upstream byte stream into a local buffer, then replays it R times on the Ethernet byte interface. Each copy has its copy index 1..R in the low nibble of the byte at offset WHEREISID, and copies are separated by a fixed inter-frame gap. It sits between the packet generator and the MAC/PHY byte transmitter.

---
 rtl/one2five_pkg.sv | 15 +
 rtl/one2five_buf.sv | 21 ++
 rtl/one2five_tx.sv | 128 ++++++++++++
 tb/tb_one2five_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/one2five_pkg.sv
// Shared types and defaults for the one2five redundancy link (transmitter and receiver).
package one2five_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        GAP,
        SEND
    } state_t;

    localparam int ID_W        = 4;
    localparam int R_DEFAULT   = 5;
    localparam int IFG_DEFAULT = 12;

endpackage

// File: rtl/one2five_buf.sv
// Frame buffer: simple dual-port RAM, one write port, registered one-cycle read.
module one2five_buf #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/one2five_tx.sv
// Captures one frame, then replays it R times with the copy index in the id byte.
// Build option ONE2FIVE_SEQ_EN: id byte upper nibble carries a per-frame sequence number.
module one2five_tx
    import one2five_pkg::*;
#(
    parameter int WHEREISID = 0,
    parameter int R         = R_DEFAULT,
    parameter int IFG       = IFG_DEFAULT,
    parameter int MAXLEN    = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       en_in,
    output logic [7:0] txd,
    output logic       txen,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int LEN_W = $clog2(MAXLEN + 1);
    localparam int AW    = $clog2(MAXLEN);
    localparam int GAP_W = $clog2(IFG + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG - 1);

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len, rd_addr;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ID_W-1:0]   copy, id_lo;
    logic              armed, txen_r, id_sel;
    logic              we, start, drop_new, last_rd, too_short;
    logic [AW-1:0]     waddr;
    logic [7:0]        rdata;
`ifdef ONE2FIVE_SEQ_EN
    logic [ID_W-1:0]   seq, id_hi;
`endif

    // armed is only set while en_in is low, so armed && en_in marks the first byte of a run
    assign start     = (state == IDLE) && en_in && armed && !busy;
    assign drop_new  = busy && en_in && armed;
    assign last_rd   = (state == SEND) && (rd_addr == len - LEN_W'(1));
    assign too_short = (state == CAPTURE) && !en_in && (len <= LEN_W'(WHEREISID));

    one2five_buf #(
        .DEPTH (MAXLEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (rd_addr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: if (!en_in) state_nxt = too_short ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = SEND;
            SEND:    if (last_rd) state_nxt = (copy < ID_W'(R)) ? GAP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == GAP) || (state == SEND) || txen_r;
        we    = start || ((state == CAPTURE) && en_in && (len < LEN_W'(MAXLEN)));
        waddr = start ? '0 : len[AW-1:0];
        txen  = txen_r;
        txd   = '0;
        if (txen_r) begin
            txd = rdata;
            if (id_sel) begin
                txd[ID_W-1:0] = id_lo;
`ifdef ONE2FIVE_SEQ_EN
                txd[7:ID_W] = id_hi;
`endif
            end
        end
    end

    // id nibbles are latched alongside the read so a last-byte id sees the pre-increment copy/seq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            rd_addr  <= '0;
            gap_cnt  <= '0;
            copy     <= '0;
            id_lo    <= '0;
            armed    <= 1'b0;
            txen_r   <= 1'b0;
            id_sel   <= 1'b0;
            drop_cnt <= '0;
`ifdef ONE2FIVE_SEQ_EN
            seq      <= '0;
            id_hi    <= '0;
`endif
        end else begin
            armed <= !en_in || (armed && !drop_new);
            if ((drop_new || too_short) && (drop_cnt != '1)) drop_cnt <= drop_cnt + 8'd1;

            if (start) len <= LEN_W'(1);
            else if (we) len <= len + LEN_W'(1);

            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            rd_addr <= ((state == SEND) && !last_rd) ? rd_addr + LEN_W'(1) : '0;

            if (state == CAPTURE) copy <= ID_W'(1);
            else if (last_rd) copy <= copy + ID_W'(1);

            txen_r <= (state == SEND);
            id_sel <= (state == SEND) && (rd_addr == LEN_W'(WHEREISID));
            id_lo  <= copy;
`ifdef ONE2FIVE_SEQ_EN
            id_hi  <= seq;
            if (last_rd && (copy == ID_W'(R))) seq <= seq + ID_W'(1);
`endif
        end
    end

endmodule

// File: tb/tb_one2five_tx.sv
// Self-checking bench for one2five_tx: random frames against a copy/gap/id reference model.
module tb_one2five_tx;
    import one2five_pkg::*;

    localparam int WID  = 2;
    localparam int RR   = 5;
    localparam int GAPC = 12;
    localparam int ML   = 64;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       en_in = 1'b0;
    logic [7:0] txd;
    logic       txen, busy;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int seq_m = 0;
    int cyc = 0;
    bq_t frm;

    one2five_tx #(.WHEREISID(WID), .R(RR), .IFG(GAPC), .MAXLEN(ML)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .en_in(en_in),
        .txd(txd), .txen(txen), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collects transmitted bytes, run lengths, gaps, start cycles and busy edges
    logic [7:0] got_b[$];
    int got_len[$], got_gap[$], got_start[$];
    int run_len = 0, low_len = 0, busy_rise = -1, busy_fall = -1, busy_hi_cnt = 0;
    logic prev_txen = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (txen) begin
            if (!prev_txen) begin
                got_start.push_back(cyc);
                got_gap.push_back(low_len);
                run_len = 0;
            end
            got_b.push_back(txd);
            run_len++;
            low_len = 0;
        end else begin
            if (prev_txen) got_len.push_back(run_len);
            low_len++;
        end
        if (busy && !prev_busy) busy_rise = cyc;
        if (!busy && prev_busy) busy_fall = cyc;
        if (busy) busy_hi_cnt++;
        prev_txen = txen;
        prev_busy = busy;
    end

    task automatic mon_clear();
        got_b.delete(); got_len.delete(); got_gap.delete(); got_start.delete();
        busy_rise = -1; busy_fall = -1; busy_hi_cnt = 0; low_len = 0;
        prev_txen = txen; prev_busy = busy;
    endtask

    function automatic logic [7:0] exp_byte(int c, int i);
        logic [7:0] b;
        b = frm[i];
        if (i == WID) begin
`ifdef ONE2FIVE_SEQ_EN
            b[7:4] = seq_m[3:0];
`endif
            b[3:0] = c[3:0];
        end
        return b;
    endfunction

    task automatic drive_frame(input bq_t f, output int t_low);
        foreach (f[i]) begin
            @(posedge clk); #1;
            data_in = f[i];
            en_in = 1'b1;
        end
        @(posedge clk); #1;
        en_in = 1'b0;
        data_in = 8'h00;
        t_low = cyc;
    endtask

    task automatic wait_done(input int nc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk); #1;
            if (got_len.size() >= nc && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (txd !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h want 00", txd); end
        n_cmp++; if (txen !== 1'b0) begin n_fail++; $display("FAIL reset_txen: got %b want 0", txen); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef ONE2FIVE_SEQ_EN
    task automatic test_seq();
        int t;
        bit ok;
        logic [7:0] want;
        for (int f = 0; f < 3; f++) begin
            frm.delete();
            for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
            frm[2] = 8'hA0;
            @(posedge clk); #1; mon_clear();
            drive_frame(frm, t);
            wait_done(RR, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL seq_timeout: frame %0d got %0d copies want %0d", f, got_len.size(), RR); end
            for (int c = 0; c < RR; c++) begin
                want = 8'((f << 4) | (c + 1));
                n_cmp++;
                if (c * 6 + 2 >= got_b.size() || got_b[c * 6 + 2] !== want) begin
                    n_fail++;
                    $display("FAIL seq_id f%0d c%0d: got %h want %h", f, c,
                             (c * 6 + 2 < got_b.size()) ? got_b[c * 6 + 2] : 8'hxx, want);
                end
            end
            seq_m++;
        end
    endtask
`endif

    task automatic test_replay();
        int lens[6];
        int t, L, bad;
        bit ok;
        logic [7:0] d0;
        lens = '{10, 3, ML + 5, ML, 0, 0};
        lens[4] = $urandom_range(4, 30);
        lens[5] = $urandom_range(31, ML - 1);
        foreach (lens[f]) begin
            frm.delete();
            for (int i = 0; i < lens[f]; i++) frm.push_back((f == 0) ? 8'(i) : 8'($urandom));
            L = (lens[f] > ML) ? ML : lens[f];
            d0 = drop_cnt;
            @(posedge clk); #1; mon_clear();
            drive_frame(frm, t);
            wait_done(RR, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL replay_timeout[%0d]: got %0d copies want %0d", f, got_len.size(), RR); end
            n_cmp++; if (got_len.size() !== RR) begin n_fail++; $display("FAIL replay_ncopies[%0d]: got %0d want %0d", f, got_len.size(), RR); end
            for (int c = 0; c < got_len.size(); c++) begin
                n_cmp++; if (got_len[c] !== L) begin n_fail++; $display("FAIL replay_len[%0d] c%0d: got %0d want %0d", f, c, got_len[c], L); end
                bad = 0;
                for (int i = 0; i < L; i++)
                    if (c * L + i >= got_b.size() || got_b[c * L + i] !== exp_byte(c + 1, i)) bad++;
                n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL replay_data[%0d] c%0d: %0d bytes differ, want 0", f, c, bad); end
                if (c > 0) begin
                    n_cmp++; if (got_gap[c] !== GAPC) begin n_fail++; $display("FAIL replay_gap[%0d] c%0d: got %0d want %0d", f, c, got_gap[c], GAPC); end
                end
            end
            n_cmp++;
            if (got_start.size() == 0 || got_start[0] !== t + GAPC + 2) begin
                n_fail++;
                $display("FAIL replay_first[%0d]: got %0d want %0d", f, (got_start.size() > 0) ? got_start[0] : -1, t + GAPC + 2);
            end
            n_cmp++; if (busy_rise !== t + 1) begin n_fail++; $display("FAIL busy_rise[%0d]: got %0d want %0d", f, busy_rise, t + 1); end
            n_cmp++; if (busy_fall !== t + 2 + RR * (GAPC + L)) begin n_fail++; $display("FAIL busy_fall[%0d]: got %0d want %0d", f, busy_fall, t + 2 + RR * (GAPC + L)); end
            n_cmp++; if (drop_cnt !== d0) begin n_fail++; $display("FAIL replay_drop[%0d]: got %0d want %0d", f, drop_cnt, d0); end
            seq_m++;
        end
    endtask

    task automatic test_short();
        int t;
        logic [7:0] d0;
        frm.delete();
        frm.push_back(8'($urandom));
        frm.push_back(8'($urandom));
        d0 = drop_cnt;
        @(posedge clk); #1; mon_clear();
        drive_frame(frm, t);
        repeat (40) @(negedge clk);
        #1;
        n_cmp++; if (got_start.size() !== 0) begin n_fail++; $display("FAIL short_txen: got %0d copies want 0", got_start.size()); end
        n_cmp++; if (busy_hi_cnt !== 0) begin n_fail++; $display("FAIL short_busy: busy high %0d cycles want 0", busy_hi_cnt); end
        n_cmp++; if (drop_cnt !== 8'(d0 + 1)) begin n_fail++; $display("FAIL short_drop: got %0d want %0d", drop_cnt, 8'(d0 + 1)); end
    endtask

    task automatic test_overlap();
        bq_t f2;
        int t, t2, bad;
        bit ok;
        logic [7:0] d0;
        frm.delete();
        for (int i = 0; i < 8; i++) begin
            frm.push_back(8'($urandom));
            f2.push_back(8'($urandom));
        end
        d0 = drop_cnt;
        @(posedge clk); #1; mon_clear();
        drive_frame(frm, t);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (got_start.size() >= 3) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL overlap_wait: got %0d copies want 3", got_start.size()); end
        drive_frame(f2, t2);
        wait_done(RR, ok);
        repeat (60) @(negedge clk);
        #1;
        n_cmp++; if (got_len.size() !== RR) begin n_fail++; $display("FAIL overlap_ncopies: got %0d want %0d", got_len.size(), RR); end
        bad = 0;
        for (int c = 0; c < RR; c++)
            for (int i = 0; i < 8; i++)
                if (c * 8 + i >= got_b.size() || got_b[c * 8 + i] !== exp_byte(c + 1, i)) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL overlap_data: %0d bytes differ, want 0", bad); end
        n_cmp++; if (drop_cnt !== 8'(d0 + 1)) begin n_fail++; $display("FAIL overlap_drop: got %0d want %0d", drop_cnt, 8'(d0 + 1)); end
        seq_m++;
    endtask

    task automatic test_rst_mid();
        int t, bad;
        bit ok;
        frm.delete();
        for (int i = 0; i < 10; i++) frm.push_back(8'($urandom));
        @(posedge clk); #1; mon_clear();
        drive_frame(frm, t);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (got_start.size() >= 2) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_wait: got %0d copies want 2", got_start.size()); end
        @(posedge clk); #1;
        en_in = 1'b1;
        data_in = 8'($urandom);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (txen !== 1'b0) begin n_fail++; $display("FAIL rst_txen: got %b want 0", txen); end
        n_cmp++; if (txd !== 8'h00) begin n_fail++; $display("FAIL rst_txd: got %h want 00", txd); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; data_in = 8'($urandom); end
        en_in = 1'b0;
        seq_m = 0;
        mon_clear();
        repeat (40) @(negedge clk);
        #1;
        n_cmp++;
        if (got_start.size() !== 0 || busy_hi_cnt !== 0) begin
            n_fail++;
            $display("FAIL rst_ignored_run: got %0d copies / %0d busy cycles want 0/0", got_start.size(), busy_hi_cnt);
        end
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        @(posedge clk); #1; mon_clear();
        drive_frame(frm, t);
        wait_done(RR, ok);
        n_cmp++; if (got_len.size() !== RR) begin n_fail++; $display("FAIL rst_ncopies: got %0d want %0d", got_len.size(), RR); end
        bad = 0;
        for (int c = 0; c < RR; c++) begin
            if (c < got_len.size() && got_len[c] !== 6) bad++;
            for (int i = 0; i < 6; i++)
                if (c * 6 + i >= got_b.size() || got_b[c * 6 + i] !== exp_byte(c + 1, i)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rst_after_data: %0d errors want 0", bad); end
        n_cmp++; if (got_start.size() == 0 || got_start[0] !== t + GAPC + 2) begin n_fail++; $display("FAIL rst_after_first: start wrong, want %0d", t + GAPC + 2); end
        seq_m++;
    endtask

    initial begin
        test_reset();
`ifdef ONE2FIVE_SEQ_EN
        test_seq();
`endif
        test_replay();
        test_short();
        test_overlap();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
